desagrupate: RTL and testbench
==============================

DESAGRUPATE -- requirements
Module: desagrupate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one output word.
REQ-002 SHALL have parameter GROUP_SIZE, default 4, words per input group (power of two, >=2).
REQ-003 SHALL have parameter LOG_MAX_ITERS, default 16, width of num_iters.
REQ-004 SHALL have parameter LOG_MAX_READS_PER_ITER, default 16, width of num_reads_per_iter.
REQ-005 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-007 SHALL have port configure  in  1  loads num_iters and num_reads_per_iter.
REQ-008 SHALL have port num_iters  in  LOG_MAX_ITERS  iterations per run.
REQ-009 SHALL have port num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  groups per iteration.
REQ-010 SHALL have port data_in  in  GROUP_SIZE*DATA_WIDTH  packed group, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 SHALL have port valid_in  in  1  data_in valid.
REQ-012 SHALL have port avail_out  out  1  block can accept a group this cycle.
REQ-013 SHALL have port data_out  out  DATA_WIDTH  current output word.
REQ-014 SHALL have port valid_out  out  1  data_out valid.
REQ-015 SHALL have port avail_in  in  1  downstream can accept a word this cycle.
REQ-016 SHALL have port last_out  out  1  marks final word of the run.

Function
REQ-017 Input transfer SHALL occur on an edge where valid_in and avail_out are both high; output transfer where valid_out and avail_in are both high.
REQ-018 FSM states SHALL be IDLE and RUN; configure high in any state SHALL latch both counts, clear holding register and all counters, and enter RUN next cycle.
REQ-019 Entry into RUN with num_iters==0 or num_reads_per_iter==0 SHALL return to IDLE next cycle without asserting avail_out.
REQ-020 In IDLE, avail_out and valid_out SHALL be 0.
REQ-021 A single group holding register SHALL capture data_in on input transfer; valid_out SHALL be high from the following cycle until its last lane transfers.
REQ-022 Words SHALL be emitted lane 0 first, lane counter advancing by one per output transfer, wrapping to 0 after lane GROUP_SIZE-1.
REQ-023 avail_out SHALL be high in RUN when the holding register is empty, or when lane GROUP_SIZE-1 is transferring this cycle and groups remain, giving sustained throughput of one group per GROUP_SIZE cycles.
REQ-024 With avail_in low, data_out, valid_out and last_out SHALL hold stable.
REQ-025 Read counter SHALL increment per accepted group, wrapping to 0 at num_reads_per_iter and incrementing the iteration counter.
REQ-026 After num_iters*num_reads_per_iter groups are accepted, avail_out SHALL stay low.
REQ-027 last_out SHALL be high only with the final lane of the final group; its output transfer SHALL return the FSM to IDLE.
REQ-028 Group latency: accepted at edge N, lane 0 presented after edge N, lane k transferable no earlier than edge N+1+k.

Reset
REQ-029 rst high SHALL asynchronously force IDLE, counters and latched counts to 0, holding register empty, avail_out=0, valid_out=0, last_out=0, data_out=0.
REQ-030 Reset mid-run SHALL discard any held group; no word from it SHALL appear after release.

Structure
REQ-031 Default widths and state encoding SHALL live in the shared RTL package used by AGRUPATE.
REQ-032 The block SHALL be one module; no sub-module is required.

Verification
REQ-033 Config 1 iter x 2 reads, avail_in=1, groups {4,3,2,1},{8,7,6,5} (lane3..0) -> data_out 1,2,3,4,5,6,7,8 on consecutive cycles, last_out with 8, then IDLE.
REQ-034 Same run, avail_in toggles 1/0 each cycle -> same sequence, each word held stable while avail_in=0, no loss or duplication.
REQ-035 Config 2 iters x 4 reads, valid_in always 1 -> exactly 8 groups accepted, 32 words out, avail_out low after 8th acceptance.
REQ-036 Config num_iters=0 -> avail_out never asserts, FSM back in IDLE within 2 cycles.
REQ-037 rst pulse after lane 1 of a group -> valid_out=0 immediately; after reconfigure, next word is lane 0 of new group.
REQ-038 configure asserted mid-run -> held group flushed, counters restart, new count applies.

Source files
------------

// File: rtl/desagrupate_pkg.sv
// Shared defaults and FSM encoding for the group packer/unpacker blocks.
package desagrupate_pkg;

  localparam int DEF_DATA_WIDTH             = 16;
  localparam int DEF_GROUP_SIZE             = 4;
  localparam int DEF_LOG_MAX_ITERS          = 16;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/desagrupate_if.sv
// Group-in / word-out handshake bundle for desagrupate.
interface desagrupate_if import desagrupate_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GROUP_SIZE = DEF_GROUP_SIZE
) ();

  logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in;
  logic                             valid_in;
  logic                             avail_out;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             valid_out;
  logic                             avail_in;
  logic                             last_out;

  modport slave (
    input  data_in, valid_in, avail_in,
    output avail_out, data_out, valid_out, last_out
  );

  modport master (
    output data_in, valid_in, avail_in,
    input  avail_out, data_out, valid_out, last_out
  );

endinterface

// File: rtl/desagrupate.sv
// Splits packed groups of GROUP_SIZE words into a word stream, lane 0 first,
// for num_iters x num_reads_per_iter groups per configured run.
module desagrupate import desagrupate_pkg::*; #(
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  desagrupate_if.slave                      bus
);

  localparam int LANE_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
  localparam logic [LANE_W-1:0]                 LAST_LANE = LANE_W'(GROUP_SIZE - 1);
  localparam logic [LANE_W-1:0]                 LANE_ONE  = LANE_W'(1);
  localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE  = LOG_MAX_ITERS'(1);
  localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE  = LOG_MAX_READS_PER_ITER'(1);

  state_t state, state_nxt;

  logic [LOG_MAX_ITERS-1:0]          iters_q, iter_cnt;
  logic [LOG_MAX_READS_PER_ITER-1:0] reads_q, read_cnt;
  logic [GROUP_SIZE*DATA_WIDTH-1:0]  hold;
  logic [LANE_W-1:0]                 lane;
  logic                              full;
  logic                              hold_last;
  logic                              all_taken;

  logic run, zero_cfg, on_last_lane, valid_o, out_xfer, avail_o, in_xfer;
  logic final_read, final_group, last_o;
  logic [DATA_WIDTH-1:0] word;

  assign run          = (state == ST_RUN);
  assign zero_cfg     = (iters_q == '0) || (reads_q == '0);
  assign on_last_lane = (lane == LAST_LANE);
  assign valid_o      = run && full;
  assign out_xfer     = valid_o && bus.avail_in;
  // Refill is allowed in the same cycle the final lane leaves, so a new group
  // can follow back-to-back without a bubble.
  assign avail_o      = run && !zero_cfg && !all_taken && (!full || (out_xfer && on_last_lane));
  assign in_xfer      = bus.valid_in && avail_o;
  assign final_read   = (read_cnt == reads_q - READ_ONE);
  assign final_group  = final_read && (iter_cnt == iters_q - ITER_ONE);
  assign last_o       = valid_o && hold_last && on_last_lane;

  always_comb begin
    word = '0;
    for (int k = 0; k < GROUP_SIZE; k++) begin
      if (lane == LANE_W'(k)) word = hold[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.avail_out = avail_o;
  assign bus.valid_out = valid_o;
  assign bus.last_out  = last_o;
  assign bus.data_out  = word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (configure) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN:  if (zero_cfg || (out_xfer && last_o)) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counters, holding register and lane pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iters_q   <= '0;
      reads_q   <= '0;
      iter_cnt  <= '0;
      read_cnt  <= '0;
      hold      <= '0;
      lane      <= '0;
      full      <= 1'b0;
      hold_last <= 1'b0;
      all_taken <= 1'b0;
    end else if (configure) begin
      iters_q   <= num_iters;
      reads_q   <= num_reads_per_iter;
      iter_cnt  <= '0;
      read_cnt  <= '0;
      hold      <= '0;
      lane      <= '0;
      full      <= 1'b0;
      hold_last <= 1'b0;
      all_taken <= 1'b0;
    end else if (in_xfer) begin
      hold      <= bus.data_in;
      full      <= 1'b1;
      lane      <= '0;
      hold_last <= final_group;
      if (final_group) all_taken <= 1'b1;
      if (final_read) begin
        read_cnt <= '0;
        iter_cnt <= iter_cnt + ITER_ONE;
      end else begin
        read_cnt <= read_cnt + READ_ONE;
      end
    end else if (out_xfer) begin
      if (on_last_lane) begin
        full <= 1'b0;
        lane <= '0;
      end else begin
        lane <= lane + LANE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_desagrupate.sv
// Directed bench for desagrupate: cycle table for a basic run plus sequences
// for backpressure, multi-iteration, zero counts, reset and reconfigure.
module tb_desagrupate;

  localparam int DW = 16;
  localparam int GS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        configure;
  logic [15:0] num_iters;
  logic [15:0] num_reads_per_iter;

  desagrupate_if #(.DATA_WIDTH(DW), .GROUP_SIZE(GS)) bus ();

  desagrupate #(
    .DATA_WIDTH(DW), .GROUP_SIZE(GS), .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads_per_iter), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cfg;
    logic [15:0] ni;
    logic [15:0] nr;
    logic        vin;
    logic [63:0] din;
    logic        ain;
    logic        e_avail;
    logic        e_valid;
    logic        e_last;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[12];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic cfg, logic [15:0] ni, logic [15:0] nr, logic vin,
                              logic [63:0] din, logic ain, logic ea, logic ev,
                              logic el, logic [15:0] ed);
    vec_t v;
    v.cfg = cfg; v.ni = ni; v.nr = nr; v.vin = vin; v.din = din; v.ain = ain;
    v.e_avail = ea; v.e_valid = ev; v.e_last = el; v.e_data = ed;
    return v;
  endfunction

  function automatic logic [63:0] grp(int g);
    logic [15:0] w0, w1, w2, w3;
    w0 = 16'(g*4 + 1); w1 = 16'(g*4 + 2); w2 = 16'(g*4 + 3); w3 = 16'(g*4 + 4);
    return {w3, w2, w1, w0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples outputs at the falling edge, then advances past the next rising edge.
  task automatic expect_out(input string tag, input logic ea, input logic ev,
                            input logic el, input logic [15:0] ed, input bit cd);
    @(negedge clk);
    chk({tag, ".avail"}, 32'(bus.avail_out), 32'(ea));
    chk({tag, ".valid"}, 32'(bus.valid_out), 32'(ev));
    chk({tag, ".last"},  32'(bus.last_out),  32'(el));
    if (cd) chk({tag, ".data"}, 32'(bus.data_out), 32'(ed));
    tick();
  endtask

  task automatic drive(input logic cfg, input int ni, input int nr, input logic vin,
                       input logic [63:0] din, input logic ain);
    configure = cfg; num_iters = 16'(ni); num_reads_per_iter = 16'(nr);
    bus.valid_in = vin; bus.data_in = din; bus.avail_in = ain;
  endtask

  task automatic run_stream(input int ni, input int nr, input bit toggle, input string tag);
    int total;
    int g;
    int w;
    int cyc;
    bit was_held;
    bit done;
    logic [15:0] held;
    total = ni * nr; g = 0; w = 0; cyc = 0; was_held = 0; done = 0; held = '0;
    drive(1'b1, ni, nr, 1'b0, '0, 1'b1);
    tick();
    configure = 1'b0;
    while (!done && cyc < 400) begin
      bus.avail_in = toggle ? ((cyc % 2) == 0) : 1'b1;
      bus.valid_in = (g < total);
      bus.data_in  = grp(g);
      @(negedge clk);
      if (was_held) begin
        chk({tag, ".hold_data"},  32'(bus.data_out),  32'(held));
        chk({tag, ".hold_valid"}, 32'(bus.valid_out), 32'd1);
      end
      if (g == total) chk({tag, ".avail_after_all"}, 32'(bus.avail_out), 32'd0);
      if (bus.valid_in && bus.avail_out) g++;
      if (bus.valid_out && bus.avail_in) begin
        chk($sformatf("%s.word%0d", tag, w), 32'(bus.data_out), 32'(w + 1));
        chk($sformatf("%s.last%0d", tag, w), 32'(bus.last_out), 32'(w == total*GS - 1));
        w++;
        if (bus.last_out) done = 1;
      end
      was_held = bus.valid_out && !bus.avail_in;
      held     = bus.data_out;
      tick();
      cyc++;
    end
    chk({tag, ".finished"}, 32'(done), 32'd1);
    chk({tag, ".groups"},   32'(g), 32'(total));
    chk({tag, ".words"},    32'(w), 32'(total*GS));
    for (int i = 0; i < 3; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = grp(50);
      expect_out($sformatf("%s.idle%0d", tag, i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 2, 0, '0,      1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 2, 1, grp(0),  1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 2, 1, grp(1),  1, 0, 1, 0, 1);
    tbl[3]  = mk(0, 1, 2, 1, grp(1),  1, 0, 1, 0, 2);
    tbl[4]  = mk(0, 1, 2, 1, grp(1),  1, 0, 1, 0, 3);
    tbl[5]  = mk(0, 1, 2, 1, grp(1),  1, 1, 1, 0, 4);
    tbl[6]  = mk(0, 1, 2, 1, grp(7),  1, 0, 1, 0, 5);
    tbl[7]  = mk(0, 1, 2, 1, grp(7),  1, 0, 1, 0, 6);
    tbl[8]  = mk(0, 1, 2, 1, grp(7),  1, 0, 1, 0, 7);
    tbl[9]  = mk(0, 1, 2, 1, grp(7),  1, 0, 1, 1, 8);
    tbl[10] = mk(0, 1, 2, 1, grp(7),  1, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 2, 1, grp(0),  1, 0, 0, 0, 0);

    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, '0, 1'b0);
    #12;
    chk("reset.avail", 32'(bus.avail_out), 32'd0);
    chk("reset.valid", 32'(bus.valid_out), 32'd0);
    chk("reset.last",  32'(bus.last_out),  32'd0);
    chk("reset.data",  32'(bus.data_out),  32'd0);
    tick();
    rst = 1'b0;

    // Basic 1 x 2 run, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].cfg, int'(tbl[i].ni), int'(tbl[i].nr), tbl[i].vin, tbl[i].din, tbl[i].ain);
      expect_out($sformatf("vec%0d", i), tbl[i].e_avail, tbl[i].e_valid, tbl[i].e_last,
                 tbl[i].e_data, tbl[i].e_valid);
    end

    run_stream(1, 2, 1'b1, "toggle");
    run_stream(2, 4, 1'b0, "iter2x4");

    // Zero counts never open the input side
    drive(1'b1, 0, 3, 1'b1, grp(0), 1'b1);
    tick();
    configure = 1'b0;
    for (int i = 0; i < 4; i++) expect_out($sformatf("zero_it%0d", i), 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 2, 0, 1'b1, grp(0), 1'b1);
    tick();
    configure = 1'b0;
    for (int i = 0; i < 3; i++) expect_out($sformatf("zero_rd%0d", i), 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Reset in the middle of a group
    drive(1'b1, 1, 2, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1, 2, 1'b1, 64'h000E_000D_000C_000B, 1'b1);
    expect_out("rst.accept", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bus.valid_in = 1'b0;
    expect_out("rst.lane0", 1'b0, 1'b1, 1'b0, 16'h000B, 1'b1);
    expect_out("rst.lane1", 1'b0, 1'b1, 1'b0, 16'h000C, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst.async_valid", 32'(bus.valid_out), 32'd0);
    chk("rst.async_data",  32'(bus.data_out),  32'd0);
    chk("rst.async_avail", 32'(bus.avail_out), 32'd0);
    chk("rst.async_last",  32'(bus.last_out),  32'd0);
    tick();
    rst = 1'b0;
    expect_out("rst.after", 1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1, 1, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1, 1, 1'b1, 64'h0018_0017_0016_0015, 1'b1);
    expect_out("rst.new_accept", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bus.valid_in = 1'b0;
    for (int k = 0; k < GS; k++)
      expect_out($sformatf("rst.new%0d", k), 1'b0, 1'b1, 1'b0 | (k == GS-1), 16'(16'h15 + k), 1'b1);
    expect_out("rst.new_idle", 1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Reconfigure in the middle of a run
    drive(1'b1, 1, 2, 1'b0, '0, 1'b1);
    tick();
    drive(1'b0, 1, 2, 1'b1, 64'h0022_0021_0020_001F, 1'b1);
    expect_out("recfg.accept", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bus.valid_in = 1'b0;
    expect_out("recfg.lane0", 1'b0, 1'b1, 1'b0, 16'h001F, 1'b1);
    drive(1'b1, 1, 1, 1'b0, '0, 1'b0);
    expect_out("recfg.cfg", 1'b0, 1'b1, 1'b0, 16'h0020, 1'b1);
    drive(1'b0, 1, 1, 1'b0, '0, 1'b1);
    expect_out("recfg.flushed", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1, 1, 1'b1, 64'h002C_002B_002A_0029, 1'b1);
    expect_out("recfg.accept2", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < GS; k++)
      expect_out($sformatf("recfg.new%0d", k), 1'b0, 1'b1, 1'b0 | (k == GS-1), 16'(16'h29 + k), 1'b1);
    expect_out("recfg.idle", 1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
